// File: rtl/axis_pkt_master.sv
// AXI4-Stream packet master.
//
// Words pushed on the write side are buffered in a FIFO and presented on an
// AXI4-Stream master port through a single output register (EMPTY/HOLD stage).
// tlast is the stored wr_last flag OR'd with an automatic end-of-packet marker
// generated every PKT_WORDS beats (PKT_WORDS=0 disables the automatic marker).
//
// Optional feature: define AXIS_PKT_MASTER_STATS_EN to add the beat_total and
// pkt_total handshake counters as extra outputs.
//
// Ports:
//   m00_axis_aclk    clock
//   m00_axis_areset  synchronous active-high reset
//   wr_en/wr_data    push request and data
//   wr_last          force tlast on the pushed word
//   flush            discard all buffered words not yet presented
//   wr_full          FIFO holds FIFO_DEPTH words
//   overflow         sticky: a push was dropped because the FIFO was full
//   fifo_count       words buffered, excluding the output register
//   m00_axis_*       AXI4-Stream master (tvalid/tdata/tstrb/tlast/tready)
//   beat_total       (STATS_EN) handshake count, wraps at 2^32
//   pkt_total        (STATS_EN) handshakes with tlast=1, wraps at 2^32
module axis_pkt_master #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH           = 16,
  parameter int unsigned PKT_WORDS            = 4
) (
  input  logic                                 m00_axis_aclk,
  input  logic                                 m00_axis_areset,
  input  logic                                 wr_en,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]      wr_data,
  input  logic                                 wr_last,
  input  logic                                 flush,
  output logic                                 wr_full,
  output logic                                 overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]      m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]    m00_axis_tstrb,
  output logic                                 m00_axis_tlast,
  input  logic                                 m00_axis_tready
`ifdef AXIS_PKT_MASTER_STATS_EN
  ,
  output logic [31:0]                          beat_total,
  output logic [31:0]                          pkt_total
`endif
);

  localparam int unsigned DW = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = (PKT_WORDS == 0) ? 1 : $clog2(PKT_WORDS + 1);

  localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);
  localparam bit            AutoEn    = (PKT_WORDS != 0);
  localparam logic [BW-1:0] LastBeat  = AutoEn ? BW'(PKT_WORDS - 1) : '0;

  typedef enum logic [0:0] {StEmpty, StHold} state_e;

  // FIFO storage: {last, data}
  logic [DW:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  // Output stage
  state_e          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;

  // Packet beat counter and deferred flush clear
  logic [BW-1:0]   beat_q, beat_d;
  logic            flush_pend_q, flush_pend_d;

  logic            full;
  logic            push;
  logic            hs;
  logic            load;
  logic            tlast_int;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    full      = (count_q == FullCount);
    // A full FIFO drops the push even if a pop frees a slot this same cycle.
    push      = wr_en & ~full & ~flush;
    hs        = (state_q == StHold) & m00_axis_tready;
    tlast_int = (state_q == StHold) & (last_q | (AutoEn && (beat_q == LastBeat)));
    // Flush discards everything not yet presented, so it also blocks a reload.
    load      = ~flush & (count_q != '0) & ((state_q == StEmpty) | hs);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (load) state_d = StHold;
      StHold:  if (hs && !load) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m00_axis_tvalid = (state_q == StHold);
    m00_axis_tdata  = data_q;
    m00_axis_tlast  = tlast_int;
    m00_axis_tstrb  = '1;
    wr_full         = full;
    overflow        = overflow_q;
    fifo_count      = count_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d     = data_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full);

    if (load) begin
      {last_d, data_d} = mem_q[rd_ptr_q];
      rd_ptr_d         = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (flush) begin
      // push and load are both blocked, so the write pointer is stable.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      unique case ({push, load})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Beat counter: a flush while a beat is held waits for that beat to complete.
  always_comb begin
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    if (hs) begin
      beat_d       = (tlast_int || flush_pend_q || flush) ? '0 : beat_q + BW'(1);
      flush_pend_d = 1'b0;
    end else if (flush) begin
      if (state_q == StHold) begin
        flush_pend_d = 1'b1;
      end else begin
        beat_d = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge m00_axis_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      data_q       <= data_d;
      last_q       <= last_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef AXIS_PKT_MASTER_STATS_EN
  // ---------------------------------------------------------------------------
  // Handshake statistics
  // ---------------------------------------------------------------------------
  logic [31:0] beat_total_q, beat_total_d;
  logic [31:0] pkt_total_q, pkt_total_d;

  always_comb begin
    beat_total_d = beat_total_q;
    pkt_total_d  = pkt_total_q;
    if (hs) begin
      beat_total_d = beat_total_q + 32'd1;
      if (tlast_int) begin
        pkt_total_d = pkt_total_q + 32'd1;
      end
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      beat_total_q <= '0;
      pkt_total_q  <= '0;
    end else begin
      beat_total_q <= beat_total_d;
      pkt_total_q  <= pkt_total_d;
    end
  end

  assign beat_total = beat_total_q;
  assign pkt_total  = pkt_total_q;
`endif

endmodule

// File: tb/tb_axis_pkt_master.sv
// Self-checking bench for axis_pkt_master: a default instance (PKT_WORDS=4)
// and a PKT_WORDS=0 instance share all inputs; each test checks one of them.
module tb_axis_pkt_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        flush;
  logic        tready;

  logic        a_full, a_ovf, a_tvalid, a_tlast;
  logic [4:0]  a_cnt;
  logic [31:0] a_tdata;
  logic [3:0]  a_tstrb;
  logic        b_full, b_ovf, b_tvalid, b_tlast;
  logic [4:0]  b_cnt;
  logic [31:0] b_tdata;
  logic [3:0]  b_tstrb;
`ifdef AXIS_PKT_MASTER_STATS_EN
  logic [31:0] a_beats, a_pkts, b_beats, b_pkts;
`endif

  always #5 clk = ~clk;

  axis_pkt_master u_dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_last         (wr_last),
    .flush           (flush),
    .wr_full         (a_full),
    .overflow        (a_ovf),
    .fifo_count      (a_cnt),
    .m00_axis_tvalid (a_tvalid),
    .m00_axis_tdata  (a_tdata),
    .m00_axis_tstrb  (a_tstrb),
    .m00_axis_tlast  (a_tlast),
    .m00_axis_tready (tready)
`ifdef AXIS_PKT_MASTER_STATS_EN
    ,
    .beat_total      (a_beats),
    .pkt_total       (a_pkts)
`endif
  );

  axis_pkt_master #(
    .PKT_WORDS (0)
  ) u_dut_nopkt (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_last         (wr_last),
    .flush           (flush),
    .wr_full         (b_full),
    .overflow        (b_ovf),
    .fifo_count      (b_cnt),
    .m00_axis_tvalid (b_tvalid),
    .m00_axis_tdata  (b_tdata),
    .m00_axis_tstrb  (b_tstrb),
    .m00_axis_tlast  (b_tlast),
    .m00_axis_tready (tready)
`ifdef AXIS_PKT_MASTER_STATS_EN
    ,
    .beat_total      (b_beats),
    .pkt_total       (b_pkts)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One record per cycle: inputs driven in that cycle, outputs expected in it.
  typedef struct {
    bit          chk_b;
    bit          en;
    logic [31:0] data;
    bit          last;
    bit          rdy;
    bit          tv;
    logic [31:0] td;
    bit          tl;
    int          cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      if (vecs[i].chk_b) begin
        chk($sformatf("v%0d tvalid", i), 32'(b_tvalid), 32'(vecs[i].tv));
        chk($sformatf("v%0d tlast", i), 32'(b_tlast), 32'(vecs[i].tl));
        chk($sformatf("v%0d count", i), 32'(b_cnt), vecs[i].cnt);
        if (vecs[i].tv) chk($sformatf("v%0d tdata", i), b_tdata, vecs[i].td);
      end else begin
        chk($sformatf("v%0d tvalid", i), 32'(a_tvalid), 32'(vecs[i].tv));
        chk($sformatf("v%0d tlast", i), 32'(a_tlast), 32'(vecs[i].tl));
        chk($sformatf("v%0d count", i), 32'(a_cnt), vecs[i].cnt);
        if (vecs[i].tv) chk($sformatf("v%0d tdata", i), a_tdata, vecs[i].td);
      end
      wr_en   = vecs[i].en;
      wr_data = vecs[i].data;
      wr_last = vecs[i].last;
      tready  = vecs[i].rdy;
    end
    @(negedge clk);
    wr_en  = 1'b0;
    tready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; flush = 1'b0; tready = 1'b0;
    @(negedge clk);
    chk("rst tvalid", 32'(a_tvalid), 32'd0);
    chk("rst tlast", 32'(a_tlast), 32'd0);
    chk("rst tdata", a_tdata, 32'd0);
    chk("rst count", 32'(a_cnt), 32'd0);
    chk("rst full", 32'(a_full), 32'd0);
    chk("rst overflow", 32'(a_ovf), 32'd0);
    chk("rst tstrb", 32'(a_tstrb), 32'hf);
    chk("rst b tvalid", 32'(b_tvalid), 32'd0);
    chk("rst b overflow", 32'(b_ovf | b_full), 32'd0);
    chk("rst b tstrb", 32'(b_tstrb), 32'hf);
`ifdef AXIS_PKT_MASTER_STATS_EN
    chk("rst beat_total", a_beats, 32'd0);
    chk("rst pkt_total", a_pkts, 32'd0);
    chk("rst b totals", b_beats | b_pkts, 32'd0);
`endif
    rst = 1'b0;
  endtask

  // Push n consecutive words (one per cycle) starting at base, tready held low.
  task automatic push_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tready  = 1'b0;
      wr_en   = 1'b1;
      wr_data = base + 32'(i);
      wr_last = 1'b0;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  logic [31:0] got_d[$];
  bit          got_l[$];
  logic [31:0] exp_d[$];
  bit          exp_l[$];

  // Accept beats on instance a with tready=1; tready drops on the final cycle
  // so no beat is consumed without being recorded.
  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      wr_en = 1'b0;
      flush = 1'b0;
      if (c == cycles - 1) begin
        tready = 1'b0;
      end else begin
        tready = 1'b1;
        if (a_tvalid) begin
          got_d.push_back(a_tdata);
          got_l.push_back(a_tlast);
        end
      end
    end
  endtask

  task automatic chk_beats(input string name);
    chk({name, " beats"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s data[%0d]", name, i), got_d[i], exp_d[i]);
      chk($sformatf("%s last[%0d]", name, i), 32'(got_l[i]), 32'(exp_l[i]));
    end
  endtask

  task automatic clear_q();
    got_d = {}; got_l = {}; exp_d = {}; exp_l = {};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int max_cnt;
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; flush = 1'b0; tready = 1'b0;

    //           b  en data  last rdy  tv  td     tl cnt
    vecs[0]  = '{0, 1, 32'h0, 0, 1,   0, 32'h0, 0, 0};
    vecs[1]  = '{0, 1, 32'h1, 0, 1,   0, 32'h0, 0, 1};
    vecs[2]  = '{0, 1, 32'h2, 0, 1,   1, 32'h0, 0, 1};
    vecs[3]  = '{0, 1, 32'h3, 0, 1,   1, 32'h1, 0, 1};
    vecs[4]  = '{0, 1, 32'h4, 0, 1,   1, 32'h2, 0, 1};
    vecs[5]  = '{0, 1, 32'h5, 0, 1,   1, 32'h3, 1, 1};
    vecs[6]  = '{0, 1, 32'h6, 0, 1,   1, 32'h4, 0, 1};
    vecs[7]  = '{0, 1, 32'h7, 0, 1,   1, 32'h5, 0, 1};
    vecs[8]  = '{0, 0, 32'h0, 0, 1,   1, 32'h6, 0, 1};
    vecs[9]  = '{0, 0, 32'h0, 0, 1,   1, 32'h7, 1, 0};
    vecs[10] = '{0, 0, 32'h0, 0, 1,   0, 32'h0, 0, 0};
    // PKT_WORDS=0 instance: wr_last only, tready 1010 while beats are held
    vecs[11] = '{1, 1, 32'hA0, 0, 0,  0, 32'h0,  0, 0};
    vecs[12] = '{1, 1, 32'hA1, 0, 0,  0, 32'h0,  0, 1};
    vecs[13] = '{1, 1, 32'hA2, 1, 1,  1, 32'hA0, 0, 1};
    vecs[14] = '{1, 0, 32'h0,  0, 0,  1, 32'hA1, 0, 1};
    vecs[15] = '{1, 0, 32'h0,  0, 1,  1, 32'hA1, 0, 1};
    vecs[16] = '{1, 0, 32'h0,  0, 0,  1, 32'hA2, 1, 0};
    vecs[17] = '{1, 0, 32'h0,  0, 1,  1, 32'hA2, 1, 0};
    vecs[18] = '{1, 0, 32'h0,  0, 0,  0, 32'h0,  0, 0};

    // Back-to-back stream with automatic tlast every 4 beats
    do_reset();
    run_vecs(0, 10);

    // Explicit tlast with stalls
    do_reset();
    run_vecs(11, 18);

    // Overflow: 17 pushes with tready=0, then one more
    do_reset();
    max_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (int'(a_cnt) > max_cnt) max_cnt = int'(a_cnt);
      wr_en = 1'b1; wr_data = 32'(i); wr_last = 1'b0; tready = 1'b0;
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf full after 17", 32'(a_full), 32'd1);
    chk("ovf count after 17", 32'(a_cnt), 32'd16);
    chk("ovf not yet set", 32'(a_ovf), 32'd0);
    chk("ovf max count", 32'(max_cnt), 32'd15);
    wr_en = 1'b1; wr_data = 32'h99;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf set", 32'(a_ovf), 32'd1);
    chk("ovf count held", 32'(a_cnt), 32'd16);
    // Push while full with a simultaneous read is still dropped
    clear_q();
    tready = 1'b1; wr_en = 1'b1; wr_data = 32'h55;
    got_d.push_back(a_tdata); got_l.push_back(a_tlast);
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf drop on read count", 32'(a_cnt), 32'd15);
    chk("ovf drop on read full", 32'(a_full), 32'd0);
    got_d.push_back(a_tdata); got_l.push_back(a_tlast);
    drain(30);
    for (int i = 0; i < 17; i++) begin
      exp_d.push_back(32'(i));
      exp_l.push_back((i % 4) == 3);
    end
    chk_beats("ovf");
    chk("ovf sticky", 32'(a_ovf), 32'd1);

    // Flush while a beat is held mid-packet
    do_reset();
    clear_q();
    push_n(32'h20, 2);
    drain(8);
    push_n(32'h10, 5);
    chk("flush pre count", 32'(a_cnt), 32'd4);
    chk("flush pre tdata", a_tdata, 32'h10);
    flush = 1'b1; wr_en = 1'b1; wr_data = 32'hEE;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    chk("flush hold tvalid", 32'(a_tvalid), 32'd1);
    chk("flush hold tdata", a_tdata, 32'h10);
    chk("flush count", 32'(a_cnt), 32'd0);
    drain(8);
    push_n(32'h30, 4);
    drain(10);
    exp_d = {32'h20, 32'h21, 32'h10, 32'h30, 32'h31, 32'h32, 32'h33};
    exp_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    chk_beats("flush");

    // Reset mid-packet, then a fresh 4-word packet
    do_reset();
    push_n(32'h40, 6);
    @(negedge clk); tready = 1'b1;
    @(negedge clk); tready = 1'b1;
    do_reset();
    clear_q();
    push_n(32'h50, 4);
    drain(10);
    exp_d = {32'h50, 32'h51, 32'h52, 32'h53};
    exp_l = {1'b0, 1'b0, 1'b0, 1'b1};
    chk_beats("post-reset");
`ifdef AXIS_PKT_MASTER_STATS_EN
    chk("stats beat_total", a_beats, 32'd4);
    chk("stats pkt_total", a_pkts, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/axis_pkt_master.md
AXIS_PKT_MASTER -- requirements
Module: axis_pkt_master

Interface
REQ-001 Parameter C_M_AXIS_TDATA_WIDTH, default 32, SHALL be the stream and write data width in bits; legal values are multiples of 8, minimum 8.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL be the buffer depth in words; legal values are powers of two, minimum 2.
REQ-003 Parameter PKT_WORDS, default 4, SHALL be the automatic packet length in beats; 0 disables automatic tlast.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be:
- m00_axis_aclk  in  1  clock
- m00_axis_areset  in  1  synchronous active-high reset
- wr_en  in  1  push request
- wr_data  in  C_M_AXIS_TDATA_WIDTH  push data
- wr_last  in  1  force tlast on this word
- flush  in  1  discard all buffered words not yet presented
- wr_full  out  1  FIFO holds FIFO_DEPTH words
- overflow  out  1  sticky; a push was dropped
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words buffered, excluding the output register
- m00_axis_tvalid  out  1  beat valid
- m00_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  beat data
- m00_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  all ones
- m00_axis_tlast  out  1  last beat of packet
- m00_axis_tready  in  1  downstream accept

Function
REQ-006 A push SHALL be accepted when wr_en=1, wr_full=0 and flush=0; the block stores {wr_last, wr_data}.
REQ-007 A push with wr_full=1 SHALL be dropped, even if a read occurs in the same cycle, and SHALL set overflow.
REQ-008 The output stage SHALL have two states:
- EMPTY: tvalid=0.
- HOLD: tvalid=1; tdata, tlast and tstrb are stable.
REQ-009 In EMPTY with fifo_count>0, the block SHALL load the head word and enter HOLD at the next edge.
REQ-010 Latency: a word pushed in cycle t into an idle block SHALL appear with tvalid=1 in cycle t+2.
REQ-011 In HOLD, a handshake (tvalid & tready) with fifo_count>0 SHALL reload the next word in the same edge, giving 1 beat/cycle sustained throughput.
REQ-012 In HOLD, a handshake with fifo_count=0 SHALL return the stage to EMPTY.
REQ-013 In HOLD without a handshake, the block SHALL NOT change tvalid, tdata or tlast.
REQ-014 The beat counter SHALL be $clog2(PKT_WORDS+1) bits wide, or 1 bit if PKT_WORDS=0.
REQ-015 tlast SHALL be the stored wr_last OR'd with (PKT_WORDS!=0 and beat counter == PKT_WORDS-1).
REQ-016 The beat counter SHALL increment on each handshake and clear to 0 on a handshake with tlast=1.
REQ-017 A simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 flush SHALL empty the FIFO in one cycle: fifo_count=0 and a same-cycle push is ignored.
REQ-019 flush SHALL NOT drop a beat already in HOLD; that beat completes normally.
REQ-020 flush SHALL clear the beat counter on the next edge unless a HOLD beat is outstanding; in that case the counter clears after that beat's handshake.

Reset
REQ-021 m00_axis_areset=1 at a clock edge SHALL set tvalid=0, tlast=0, tdata=0, fifo_count=0, wr_full=0, overflow=0, beat counter=0 and state EMPTY.
REQ-022 Reset mid-packet SHALL drop the HOLD beat and all buffered words.
REQ-023 The first beat after reset SHALL start a new packet.

Configuration
REQ-024 With AXIS_PKT_MASTER_STATS_EN defined, the block SHALL add outputs beat_total[31:0] and pkt_total[31:0].
- beat_total counts handshakes; pkt_total counts handshakes with tlast=1.
- Both wrap at 2^32 and clear on reset.
REQ-025 Without AXIS_PKT_MASTER_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 Defaults, tready=1, push 8 words 0x0..0x7 back-to-back -> tvalid from t+2, 8 consecutive beats, tlast on 0x3 and 0x7.
REQ-027 PKT_WORDS=0, push 3 words with wr_last on the 3rd, tready toggling 1010 -> tdata held stable while stalled, tlast only on the 3rd beat.
REQ-028 tready=0, push 17 words, FIFO_DEPTH=16 -> wr_full=1 after 16 pushes (or the 17th loads the output register), fifo_count never exceeds 16; a further push sets overflow=1; with tready=1, the retained words stream out in order.
REQ-029 Push 5 words, tready=0, assert flush -> HOLD beat 0x0 remains valid, fifo_count=0, after tready=1 exactly 1 beat is delivered.
REQ-030 Reset asserted mid-packet, then push 4 words -> tvalid=0 during reset, next packet tlast on its 4th beat; with STATS_EN, totals restart at 0 and read beat_total=4, pkt_total=1.
